alphaahb_v5_irq_ctrl: RTL

Interrupt controller that sits directly upstream of the AlphaAHB V5 multi-core system. It collects peripheral interrupt sources, latches them as pending, and routes each one to a target core and priority line. It drives each core's 8-bit `interrupt_req` vector and retires pending sources when the core returns a one-hot `interrupt_ack` pulse.

---
 rtl/alphaahb_v5_irq_pkg.sv | 32 +++
 rtl/alphaahb_v5_irq_src.sv | 109 ++++++++++
 rtl/alphaahb_v5_irq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alphaahb_v5_irq_pkg.sv
// -----------------------------------------------------------------------------
// alphaahb_v5_irq_pkg
// Shared constants and types for the AlphaAHB V5 interrupt controller.
//   IRQ_LINES     : priority lines per core (width of each interrupt_req byte)
//   CFG_*_BIT/LSB : field positions inside the 8-bit configuration record
//   irq_cfg_t     : packed record {enable, line[2:0], core[3:0]}
// Build option: ALPHAAHB_IRQ_EDGE_EN (edge-triggered sources) is consumed by
// the controller and source modules, not by this package.
// -----------------------------------------------------------------------------
package alphaahb_v5_irq_pkg;

    localparam int IRQ_LINES    = 8;
    localparam int CFG_EN_BIT   = 7;
    localparam int CFG_LINE_LSB = 4;
    localparam int CFG_CORE_LSB = 0;

    typedef struct packed {
        logic       enable;
        logic [2:0] line;
        logic [3:0] core;
    } irq_cfg_t;

    // Split a raw write word into the record fields.
    function automatic irq_cfg_t cfg_from_word(input logic [7:0] word);
        irq_cfg_t rec;
        rec.enable = word[CFG_EN_BIT];
        rec.line   = word[CFG_LINE_LSB +: 3];
        rec.core   = word[CFG_CORE_LSB +: 4];
        return rec;
    endfunction

endpackage

// File: rtl/alphaahb_v5_irq_src.sv
// -----------------------------------------------------------------------------
// alphaahb_v5_irq_src
// Per-source state: configuration record, edge history, pending and overflow.
// Build option: ALPHAAHB_IRQ_EDGE_EN selects edge-triggered pending with
// ack-driven clear; without it, pending follows the registered source level.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   src_irq    : this source's interrupt line
//   cfg_we     : write strobe already decoded for this source
//   cfg_wdata  : raw record word {enable, line, core}
//   clr        : (edge build only) ack-arbiter clear for this source
//   cfg        : current record
//   pending    : pending flag
//   ovf        : sticky overflow flag (always 0 in the level build)
// -----------------------------------------------------------------------------
module alphaahb_v5_irq_src
    import alphaahb_v5_irq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       src_irq,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
`ifdef ALPHAAHB_IRQ_EDGE_EN
    input  logic       clr,
`endif
    output irq_cfg_t   cfg,
    output logic       pending,
    output logic       ovf
);

    irq_cfg_t cfg_q, cfg_d;
    logic     pending_q, pending_d;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            cfg_d = cfg_from_word(cfg_wdata);
        end
    end

`ifdef ALPHAAHB_IRQ_EDGE_EN
    logic hist_q, hist_d;
    logic ovf_q, ovf_d;
    logic rise;

    // The record in force before this cycle's write gates the edge.
    assign rise   = src_irq & ~hist_q & cfg_q.enable;
    assign hist_d = src_irq;

    always_comb begin
        pending_d = pending_q;
        if (rise) begin
            pending_d = 1'b1;
        end else if (clr) begin
            pending_d = 1'b0;
        end
        // Disabling the source discards anything outstanding.
        if (cfg_we && !cfg_wdata[CFG_EN_BIT]) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        // A coincident clear consumes the old request, so nothing was lost.
        if (rise && pending_q && !clr) begin
            ovf_d = 1'b1;
        end
        if (cfg_we) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Use the enable being written this cycle so a disable drops pending
    // at the same edge as in the edge build.
    always_comb begin
        pending_d = src_irq & (cfg_we ? cfg_wdata[CFG_EN_BIT] : cfg_q.enable);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
        end
    end

    assign cfg     = cfg_q;
    assign pending = pending_q;

endmodule

// File: rtl/alphaahb_v5_irq_ctrl.sv
// -----------------------------------------------------------------------------
// alphaahb_v5_irq_ctrl
// Interrupt controller feeding the AlphaAHB V5 cores. Latches peripheral
// sources as pending, routes each to a (core, line) pair and drives a
// registered 8-bit request vector per core.
// Build option: ALPHAAHB_IRQ_EDGE_EN -- edge-triggered sources with ack clear
// and overflow tracking. Undefined: level mode, acks ignored, cfg_ovf = 0.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   src_irq        : source lines (already synchronous to clk)
//   cfg_we         : configuration write strobe
//   cfg_addr       : source index for write and readback
//   cfg_wdata      : {enable, line[2:0], core[3:0]}
//   cfg_rdata      : registered record at cfg_addr (old value on same-cycle write)
//   cfg_ovf        : sticky overflow per source
//   pending        : pending flag per source
//   interrupt_req  : per-core request byte, bit L = any pending source on (c, L)
//   interrupt_ack  : per-core one-cycle ack pulses, one source retired per bit
// -----------------------------------------------------------------------------
module alphaahb_v5_irq_ctrl
    import alphaahb_v5_irq_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int NUM_SOURCES = 16,
    localparam int AW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_SOURCES-1:0]                 src_irq,
    input  logic                                   cfg_we,
    input  logic [AW-1:0]                          cfg_addr,
    input  logic [7:0]                             cfg_wdata,
    output logic [7:0]                             cfg_rdata,
    output logic [NUM_SOURCES-1:0]                 cfg_ovf,
    output logic [NUM_SOURCES-1:0]                 pending,
    output logic [0:NUM_CORES-1][IRQ_LINES-1:0]    interrupt_req,
    input  logic [0:NUM_CORES-1][IRQ_LINES-1:0]    interrupt_ack
);

    irq_cfg_t                         src_cfg [NUM_SOURCES];
    logic [NUM_SOURCES-1:0]           src_pend;
    logic [NUM_SOURCES-1:0]           src_ovf;
    logic [NUM_SOURCES-1:0]           src_we;
    logic [NUM_SOURCES-1:0]           route_match [NUM_CORES][IRQ_LINES];

    logic [0:NUM_CORES-1][IRQ_LINES-1:0] req_q, req_d;
    logic [7:0]                          rdata_q, rdata_d;

`ifdef ALPHAAHB_IRQ_EDGE_EN
    logic [NUM_SOURCES-1:0] src_clr;
`else
    // Acks have no effect in level mode; the source must deassert itself.
    logic ack_unused;
    assign ack_unused = |interrupt_ack;
`endif

    for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_src
        assign src_we[s] = cfg_we && (cfg_addr == AW'(s));

        alphaahb_v5_irq_src u_src (
            .clk       (clk),
            .rst       (rst),
            .src_irq   (src_irq[s]),
            .cfg_we    (src_we[s]),
            .cfg_wdata (cfg_wdata),
`ifdef ALPHAAHB_IRQ_EDGE_EN
            .clr       (src_clr[s]),
`endif
            .cfg       (src_cfg[s]),
            .pending   (src_pend[s]),
            .ovf       (src_ovf[s])
        );
    end

    // Pending, enabled sources per (core, line). Sources routed to a core
    // index beyond NUM_CORES never match and so are never delivered.
    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int l = 0; l < IRQ_LINES; l++) begin
                route_match[c][l] = '0;
                for (int s = 0; s < NUM_SOURCES; s++) begin
                    route_match[c][l][s] = src_pend[s] && src_cfg[s].enable &&
                                           (src_cfg[s].core == 4'(c)) &&
                                           (src_cfg[s].line == 3'(l));
                end
            end
        end
    end

    always_comb begin
        req_d = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int l = 0; l < IRQ_LINES; l++) begin
                req_d[c][l] = |route_match[c][l];
            end
        end
    end

`ifdef ALPHAAHB_IRQ_EDGE_EN
    // Each ack bit retires the lowest-index matching source; x & -x isolates
    // that bit. Distinct (core, line) pairs never share a source, so OR-ing
    // their picks is safe.
    always_comb begin
        src_clr = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int l = 0; l < IRQ_LINES; l++) begin
                if (interrupt_ack[c][l]) begin
                    src_clr = src_clr | (route_match[c][l] &
                              (~route_match[c][l] + NUM_SOURCES'(1)));
                end
            end
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        for (int s = 0; s < NUM_SOURCES; s++) begin
            if (cfg_addr == AW'(s)) begin
                rdata_d = src_cfg[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    assign interrupt_req = req_q;
    assign cfg_rdata     = rdata_q;
    assign pending       = src_pend;
    assign cfg_ovf       = src_ovf;

endmodule
